// File: rtl/pixel_filter_pkg.sv
// Shared types and constants for the pixel filter stream engine.
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        INVERT = 2'd1,
        GRAY   = 2'd2,
        THRESH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Luma weights (sum to 256) and normalising shift
    localparam int unsigned GRAY_W_R   = 77;
    localparam int unsigned GRAY_W_G   = 150;
    localparam int unsigned GRAY_W_B   = 29;
    localparam int unsigned GRAY_SHIFT = 8;

    // Output FIFO sizing; also the total read credit budget
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/pixel_filter_op.sv
// Combinational per-pixel operator: pass, invert, grayscale or threshold.
module pixel_filter_op
    import pixel_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 3
) (
    input  mode_e                      mode_i,
    input  logic [DATA_W-1:0]          thr_i,
    input  logic [NUM_CH*DATA_W-1:0]   pix_i,
    output logic [NUM_CH*DATA_W-1:0]   pix_o
);

    localparam int unsigned GRAY_W   = DATA_W + GRAY_SHIFT;
    localparam bit          HAS_GRAY = (NUM_CH == 3);
    localparam logic [DATA_W-1:0] MAX_V = '1;

    logic [DATA_W-1:0] gray_c;

    // Weighted luma; only meaningful for three-channel pixels
    if (HAS_GRAY) begin : g_gray
        logic [GRAY_W-1:0] sum_c;
        assign sum_c = GRAY_W'(GRAY_W_R) * GRAY_W'(pix_i[0        +: DATA_W])
                     + GRAY_W'(GRAY_W_G) * GRAY_W'(pix_i[DATA_W   +: DATA_W])
                     + GRAY_W'(GRAY_W_B) * GRAY_W'(pix_i[2*DATA_W +: DATA_W]);
        assign gray_c = DATA_W'(sum_c >> GRAY_SHIFT);
    end else begin : g_no_gray
        assign gray_c = '0;
    end

    // Per-channel operator select; gray falls back to pass without three channels
    always_comb begin
        pix_o = pix_i;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            case (mode_i)
                INVERT: pix_o[c*DATA_W +: DATA_W] = MAX_V - pix_i[c*DATA_W +: DATA_W];
                THRESH: pix_o[c*DATA_W +: DATA_W] =
                            (pix_i[c*DATA_W +: DATA_W] >= thr_i) ? MAX_V : '0;
                GRAY:   if (HAS_GRAY) pix_o[c*DATA_W +: DATA_W] = gray_c;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_filter_stream.sv
// Frame walker: reads pixel memory, filters, and streams results with credit-based flow control.
module pixel_filter_stream
    import pixel_filter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         threshold,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [NUM_CH*DATA_W-1:0]  mem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*DATA_W-1:0]  out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned PIX_W = NUM_CH * DATA_W;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [DATA_W-1:0]   thr_q, thr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic                rd_valid_q, rd_last_q;
    logic                filt_valid_q, filt_last_q;
    logic [PIX_W-1:0]    filt_data_q;
    logic [PIX_W-1:0]    op_pix_c;

    logic [PIX_W-1:0]      fifo_data_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;

    logic [FIFO_CNT_W-1:0] credits_c;
    logic                  issue_c, last_addr_c, pop_c, push_c;

    // Occupied slots: FIFO entries plus reads still in the memory/filter stages
    assign credits_c   = count_q + FIFO_CNT_W'(rd_valid_q) + FIFO_CNT_W'(filt_valid_q);
    assign issue_c     = (state_q == RUN) && (credits_c < FIFO_CNT_W'(FIFO_DEPTH));
    assign last_addr_c = (addr_q == ADDR_W'(DEPTH - 1));
    assign push_c      = filt_valid_q;
    assign pop_c       = out_valid && out_ready;

    assign mem_en    = issue_c;
    assign mem_addr  = addr_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    pixel_filter_op #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_op (
        .mode_i (mode_q),
        .thr_i  (thr_q),
        .pix_i  (mem_rdata),
        .pix_o  (op_pix_c)
    );

    // Next-state logic: frame sequencing and read address generation
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode_e'(mode);
                    thr_d   = threshold;
                end
            end
            RUN: begin
                if (issue_c) begin
                    if (last_addr_c) state_d = DRAIN;
                    else             addr_d  = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (pop_c && out_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, pipeline valids and FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= PASS;
            thr_q        <= '0;
            addr_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            filt_valid_q <= 1'b0;
            filt_last_q  <= 1'b0;
            filt_data_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            thr_q        <= thr_d;
            addr_q       <= addr_d;
            rd_valid_q   <= issue_c;
            rd_last_q    <= issue_c && last_addr_c;
            filt_valid_q <= rd_valid_q;
            filt_last_q  <= rd_last_q;
            if (rd_valid_q) filt_data_q <= op_pix_c;
            if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            count_q <= count_q + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);
        end
    end

    // FIFO storage; occupancy is tracked separately so contents need no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_data_q[wr_ptr_q] <= filt_data_q;
            fifo_last_q[wr_ptr_q] <= filt_last_q;
        end
    end

endmodule

// File: tb/tb_pixel_filter_stream.sv
// Self-checking bench: directed vector table on a 4-pixel frame, randomized frames on a 256-pixel frame.
module tb_pixel_filter_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- small instance (DEPTH=4) ----------------
    logic        s_start;
    logic [1:0]  s_mode;
    logic [7:0]  s_thr;
    logic        s_mem_en;
    logic [1:0]  s_mem_addr;
    logic [23:0] s_rdata;
    logic        s_out_valid, s_out_ready, s_out_last, s_busy, s_done;
    logic [23:0] s_out_data;
    logic [23:0] smem [4];

    pixel_filter_stream #(.DATA_W(8), .NUM_CH(3), .DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .threshold(s_thr),
        .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(s_rdata),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    always @(posedge clk) if (s_mem_en) s_rdata <= smem[s_mem_addr];

    // ---------------- large instance (DEPTH=256) ----------------
    logic        b_start;
    logic [1:0]  b_mode;
    logic [7:0]  b_thr;
    logic        b_mem_en;
    logic [7:0]  b_mem_addr;
    logic [23:0] b_rdata;
    logic        b_out_valid, b_out_ready, b_out_last, b_busy, b_done;
    logic [23:0] b_out_data;
    logic [23:0] bmem [256];

    pixel_filter_stream #(.DATA_W(8), .NUM_CH(3), .DEPTH(256)) u_big (
        .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .threshold(b_thr),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) if (b_mem_en) b_rdata <= bmem[b_mem_addr];

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference filter from the arithmetic rules, channel by channel
    function automatic logic [23:0] model(input logic [1:0] md, input logic [7:0] th,
                                          input logic [23:0] p);
        int ch [3];
        int y;
        logic [23:0] r;
        for (int c = 0; c < 3; c++) ch[c] = int'(p[8*c +: 8]);
        r = p;
        case (md)
            2'd1: for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'(255 - ch[c]);
            2'd2: begin
                y = (77 * ch[0] + 150 * ch[1] + 29 * ch[2]) / 256;
                for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'(y);
            end
            2'd3: for (int c = 0; c < 3; c++) r[8*c +: 8] = (ch[c] >= int'(th)) ? 8'hFF : 8'h00;
            default: r = p;
        endcase
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  thr;
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [12];

    // One DEPTH=4 frame per group of four table entries (same mode within a group)
    task automatic run_small(input int f);
        int k;
        int cyc;
        for (int i = 0; i < 4; i++) smem[i] = vecs[f*4 + i].pix;
        @(negedge clk);
        s_mode  = vecs[f*4].mode;
        s_thr   = vecs[f*4].thr;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc = 1;
        check("small_busy", 32'(s_busy), 32'd1);
        k = 0;
        while (k < 4 && cyc < 40) begin
            if (s_out_valid) begin
                if (k == 0) check("small_first_valid_cycle", 32'(cyc), 32'd4);
                check($sformatf("small_f%0d_px%0d", f, k), 32'(s_out_data), 32'(vecs[f*4 + k].exp));
                check($sformatf("small_f%0d_last%0d", f, k), 32'(s_out_last), 32'(k == 3));
                k++;
            end
            if (k < 4) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("small_pixels_seen", 32'(k), 32'd4);
        @(negedge clk);
        check("small_done", 32'(s_done), 32'd1);
        @(negedge clk);
        check("small_done_pulse", 32'(s_done), 32'd0);
        check("small_busy_end", 32'(s_busy), 32'd0);
    endtask

    // ---------------- randomized frames on the large instance ----------------
    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_big(input logic [1:0] md, input logic [7:0] th, input int rmode,
                           input bit disturb);
        logic [23:0] expq [256];
        int got, issued, cyc, viol, unstable;
        bit have_hold;
        logic [23:0] hold_d;
        logic hold_l;
        for (int i = 0; i < 256; i++) begin
            bmem[i] = 24'($urandom);
            expq[i] = model(md, th, bmem[i]);
        end
        @(negedge clk);
        b_mode  = md;
        b_thr   = th;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        got = 0; issued = 0; cyc = 1; viol = 0; unstable = 0; have_hold = 1'b0;
        hold_d = '0; hold_l = 1'b0;
        while (!b_done && cyc < 4000) begin
            case (rmode)
                0:       b_out_ready = 1'b1;
                1:       b_out_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
                default: b_out_ready = 1'($urandom_range(0, 1));
            endcase
            if (b_mem_en) begin
                if (issued - got >= 4) viol++;
                if (int'(b_mem_addr) != issued) viol++;
                issued++;
            end
            if (have_hold && (!b_out_valid || b_out_data !== hold_d || b_out_last !== hold_l))
                unstable++;
            have_hold = b_out_valid && !b_out_ready;
            hold_d = b_out_data;
            hold_l = b_out_last;
            if (b_out_valid && b_out_ready) begin
                if (got < 256)
                    check($sformatf("big_px%0d", got), {7'd0, b_out_last, b_out_data},
                          {7'd0, got == 255, expq[got]});
                got++;
            end
            if (disturb && cyc == 20) begin
                b_start = 1'b1;
                b_mode  = ~md;
                b_thr   = ~th;
            end
            if (disturb && cyc == 21) b_start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        b_start = 1'b0;
        check("big_done_seen", 32'(b_done), 32'd1);
        check("big_pixel_count", 32'(got), 32'd256);
        check("big_read_count", 32'(issued), 32'd256);
        check("big_credit_or_addr_violations", 32'(viol), 32'd0);
        check("big_hold_unstable", 32'(unstable), 32'd0);
        b_out_ready = 1'b1;
        @(negedge clk);
        check("big_done_pulse", 32'(b_done), 32'd0);
    endtask

    task automatic check_big_reset_values(input string tag);
        check({tag, "_mem_en"},    32'(b_mem_en),    32'd0);
        check({tag, "_mem_addr"},  32'(b_mem_addr),  32'd0);
        check({tag, "_out_valid"}, 32'(b_out_valid), 32'd0);
        check({tag, "_out_data"},  32'(b_out_data),  32'd0);
        check({tag, "_out_last"},  32'(b_out_last),  32'd0);
        check({tag, "_busy"},      32'(b_busy),      32'd0);
        check({tag, "_done"},      32'(b_done),      32'd0);
    endtask

    initial begin
        bit saw_done;

        vecs[0]  = '{2'd1, 8'h00, 24'h000000, 24'hFFFFFF};
        vecs[1]  = '{2'd1, 8'h00, 24'hFF8001, 24'h007FFE};
        vecs[2]  = '{2'd1, 8'h00, 24'h102030, 24'hEFDFCF};
        vecs[3]  = '{2'd1, 8'h00, 24'hFFFFFF, 24'h000000};
        vecs[4]  = '{2'd2, 8'h00, 24'hFFFFFF, 24'hFFFFFF};
        vecs[5]  = '{2'd2, 8'h00, 24'h000064, 24'h1E1E1E};
        vecs[6]  = '{2'd2, 8'h00, 24'h00FF00, 24'h959595};
        vecs[7]  = '{2'd2, 8'h00, 24'hFF0000, 24'h1C1C1C};
        vecs[8]  = '{2'd3, 8'h80, 24'h7F80FF, 24'h00FFFF};
        vecs[9]  = '{2'd3, 8'h80, 24'h000000, 24'h000000};
        vecs[10] = '{2'd3, 8'h80, 24'h808080, 24'hFFFFFF};
        vecs[11] = '{2'd3, 8'h80, 24'h017F81, 24'h0000FF};

        reset = 1'b1;
        s_start = 1'b0; s_mode = 2'd0; s_thr = 8'd0; s_out_ready = 1'b1;
        b_start = 1'b0; b_mode = 2'd0; b_thr = 8'd0; b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        for (int i = 0; i < 256; i++) bmem[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_big_reset_values("rst");
        check("rst_small_valid", 32'(s_out_valid), 32'd0);

        for (int f = 0; f < 3; f++) run_small(f);

        run_big(2'd0, 8'h00, 1, 1'b0);
        run_big(2'($urandom_range(0, 3)), 8'($urandom), 2, 1'b1);
        run_big(2'd2, 8'h00, 0, 1'b1);

        // Reset during a frame: outputs clear, no done, then a clean frame
        @(negedge clk);
        b_mode  = 2'd0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_big_reset_values("midrst");
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (b_done) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_big(2'd3, 8'($urandom), 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
